// File: rtl/fmul_arb.sv
// fmul_arb: shares one combinational single-precision multiplier between two
// requesters. Each requester has a valid/ready request channel and a
// valid/ready response channel. A round-robin arbiter picks at most one
// request per cycle. The operands go into a stage-1 register. The product is
// then captured in the winning requester's private result buffer.
// Each requester may have at most one operation in flight.
//
// Ports:
//   clk                  clock, all state changes on the rising edge
//   rst                  synchronous active-high reset
//   req_valid[1:0]       requester i presents operands
//   req_ready[1:0]       requester i accepted this cycle (one-hot or zero)
//   req_x1_0, req_x2_0   requester 0 operands
//   req_x1_1, req_x2_1   requester 1 operands
//   rsp_valid[1:0]       result buffer i holds a result
//   rsp_ready[1:0]       requester i consumes its result this cycle
//   rsp_y_0, rsp_y_1     result buffers
module fmul_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req_x1_0,
    input  logic [31:0] req_x2_0,
    input  logic [31:0] req_x1_1,
    input  logic [31:0] req_x2_1,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_y_0,
    output logic [31:0] rsp_y_1
);

    logic        s1Valid_q, s1Valid_d;
    logic        s1Tag_q, s1Tag_d;
    logic [31:0] s1X1_q, s1X1_d;
    logic [31:0] s1X2_q, s1X2_d;
    logic        rrPtr_q, rrPtr_d;
    logic [1:0]  rspValid_q, rspValid_d;
    logic [31:0] rspY0_q, rspY0_d;
    logic [31:0] rspY1_q, rspY1_d;

    logic [1:0]  eligible;
    logic [1:0]  cand;
    logic [1:0]  grant;

    logic [23:0] mantA, mantB;
    logic [47:0] prod;
    logic        zeroOp;
    logic [9:0]  expSum;
    logic [9:0]  expBiased;
    logic [22:0] mantOut;
    logic [31:0] fmulY;
    logic        unused_bits;

    // Arbitration. A requester is blocked while its operation sits in stage 1.
    // It is also blocked while its result buffer is full and not being drained
    // this cycle. A buffer that drains this cycle is empty again before the
    // new result lands, so the grant is allowed. On a tie, the requester
    // that did not win last time is granted.
    always_comb begin
        eligible[0] = !(s1Valid_q && (s1Tag_q == 1'b0)) && !(rspValid_q[0] && !rsp_ready[0]);
        eligible[1] = !(s1Valid_q && (s1Tag_q == 1'b1)) && !(rspValid_q[1] && !rsp_ready[1]);
        cand = req_valid & eligible;
        grant = 2'b00;
        if (!rst) begin
            case (cand)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = rrPtr_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready = grant;

    // Multiplier. It reads only the stage-1 registers. The hidden-bit product is
    // normalised on its MSB and truncated. A zero operand forces the
    // exponent sum to 0. Subtracting the bias then always underflows, which
    // flushes the result to a signed zero. Exponent overflow is left to wrap.
    always_comb begin
        mantA     = {1'b1, s1X1_q[22:0]};
        mantB     = {1'b1, s1X2_q[22:0]};
        prod      = mantA * mantB;
        zeroOp    = (s1X1_q[30:0] == 31'd0) || (s1X2_q[30:0] == 31'd0);
        expSum    = zeroOp ? 10'd0 : ({2'b00, s1X1_q[30:23]} + {2'b00, s1X2_q[30:23]});
        expBiased = expSum - 10'd127 + {9'd0, prod[47]};
        mantOut   = prod[47] ? prod[46:24] : prod[45:23];
        if (expBiased[9]) begin
            fmulY = {s1X1_q[31] ^ s1X2_q[31], 31'd0};
        end else begin
            fmulY = {s1X1_q[31] ^ s1X2_q[31], expBiased[7:0], mantOut};
        end
    end

    assign unused_bits = ^{prod[22:0], expBiased[8]};

    // Next-state logic for stage 1, the round-robin pointer and the result
    // buffers. A buffer reload takes priority over a consume on the same edge.
    always_comb begin
        rrPtr_d   = rrPtr_q;
        s1Valid_d = |grant;
        s1Tag_d   = s1Tag_q;
        s1X1_d    = s1X1_q;
        s1X2_d    = s1X2_q;
        if (|grant) begin
            rrPtr_d = grant[1];
            s1Tag_d = grant[1];
            s1X1_d  = grant[1] ? req_x1_1 : req_x1_0;
            s1X2_d  = grant[1] ? req_x2_1 : req_x2_0;
        end

        rspValid_d = rspValid_q & ~rsp_ready;
        rspY0_d    = rspY0_q;
        rspY1_d    = rspY1_q;
        if (s1Valid_q && (s1Tag_q == 1'b0)) begin
            rspValid_d[0] = 1'b1;
            rspY0_d       = fmulY;
        end
        if (s1Valid_q && (s1Tag_q == 1'b1)) begin
            rspValid_d[1] = 1'b1;
            rspY1_d       = fmulY;
        end
    end

    // State registers. Reset drops everything in flight. The pointer starts
    // at 1 so that requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid_q  <= 1'b0;
            s1Tag_q    <= 1'b0;
            s1X1_q     <= 32'd0;
            s1X2_q     <= 32'd0;
            rrPtr_q    <= 1'b1;
            rspValid_q <= 2'b00;
            rspY0_q    <= 32'd0;
            rspY1_q    <= 32'd0;
        end else begin
            s1Valid_q  <= s1Valid_d;
            s1Tag_q    <= s1Tag_d;
            s1X1_q     <= s1X1_d;
            s1X2_q     <= s1X2_d;
            rrPtr_q    <= rrPtr_d;
            rspValid_q <= rspValid_d;
            rspY0_q    <= rspY0_d;
            rspY1_q    <= rspY1_d;
        end
    end

    assign rsp_valid = rspValid_q;
    assign rsp_y_0   = rspY0_q;
    assign rsp_y_1   = rspY1_q;

endmodule

// File: tb/tb_fmul_arb.sv
// tb_fmul_arb: directed testbench for fmul_arb. A cycle-level reference model
// of the arbiter, the two-stage pipe and the buffers tracks the DUT. It uses
// integer arithmetic for the multiplier. Hand-computed literals pin both the
// model and the DUT at selected cycles.
module tb_fmul_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_x1_0, req_x2_0, req_x1_1, req_x2_1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_y_0, rsp_y_1;

    int checks = 0;
    int errors = 0;

    fmul_arb dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x1_0  (req_x1_0),
        .req_x2_0  (req_x2_0),
        .req_x1_1  (req_x1_1),
        .req_x2_1  (req_x2_1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y_0   (rsp_y_0),
        .rsp_y_1   (rsp_y_1)
    );

    always #5 clk = ~clk;

    // Reference single-precision multiply. It uses plain integer arithmetic
    // on the significands and the unbiased exponent, truncates, and flushes
    // to a signed zero whenever the exponent goes negative.
    function automatic logic [31:0] refMul(input logic [31:0] a, input logic [31:0] b);
        longint      p;
        int          e;
        logic [22:0] m;
        logic        s;
        s = a[31] ^ b[31];
        p = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
        if (a[30:0] == 31'd0 || b[30:0] == 31'd0) e = -127;
        else e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p >= (64'sd1 <<< 47)) begin
            e = e + 1;
            m = p[46:24];
        end else begin
            m = p[45:23];
        end
        if (e < 0) return {s, 31'd0};
        return {s, e[7:0], m};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge. They are sampled at
    // the falling edge and stay stable through the next rising edge.
    task automatic applyStimulus(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] b0,
                                 input logic [31:0] a1, input logic [31:0] b1,
                                 input logic [1:0] rr, input logic r);
        @(posedge clk);
        #1;
        req_valid = v;
        req_x1_0  = a0;
        req_x2_0  = b0;
        req_x1_1  = a1;
        req_x2_1  = b1;
        rsp_ready = rr;
        rst       = r;
    endtask

    task automatic doReset();
        applyStimulus(2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 1'b1);
        applyStimulus(2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 1'b0);
    endtask

    // Reference model state. Each falling edge compares the DUT with the
    // model. It then advances the model to the state after the next rising
    // edge, using the inputs that will be sampled there.
    bit          armed = 1'b0;
    bit          mPipeV;
    int          mPipeTag;
    logic [31:0] mPipeY;
    logic [1:0]  mBufV;
    logic [31:0] mBufY [2];
    int          mLast;
    int          win;
    bit          want [2];
    logic [1:0]  expReady;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            want[i] = req_valid[i] && !((mPipeV && mPipeTag == i) || (mBufV[i] && !rsp_ready[i]));
        end
        if (rst) win = -1;
        else if (want[0] && want[1]) win = 1 - mLast;
        else if (want[0]) win = 0;
        else if (want[1]) win = 1;
        else win = -1;
        expReady = (win < 0) ? 2'b00 : (2'b01 << win);

        if (armed) begin
            checkOutput("model_req_ready", {30'd0, req_ready}, {30'd0, expReady});
            checkOutput("model_rsp_valid", {30'd0, rsp_valid}, {30'd0, mBufV});
            checkOutput("model_rsp_y_0", rsp_y_0, mBufY[0]);
            checkOutput("model_rsp_y_1", rsp_y_1, mBufY[1]);
        end

        if (rst) begin
            mPipeV   = 1'b0;
            mPipeTag = 0;
            mPipeY   = 32'd0;
            mBufV    = 2'b00;
            mBufY[0] = 32'd0;
            mBufY[1] = 32'd0;
            mLast    = 1;
            armed    = 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (mPipeV && mPipeTag == i) begin
                    mBufV[i] = 1'b1;
                    mBufY[i] = mPipeY;
                end else if (rsp_ready[i]) begin
                    mBufV[i] = 1'b0;
                end
            end
            mPipeV = (win >= 0);
            if (win >= 0) begin
                mPipeTag = win;
                mPipeY   = (win == 0) ? refMul(req_x1_0, req_x2_0) : refMul(req_x1_1, req_x2_1);
                mLast    = win;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    logic [31:0] zA [3];
    logic [31:0] zB [3];
    logic [31:0] zY [3];
    logic [31:0] bA [4];
    logic [31:0] bB [4];
    logic [31:0] bY [4];
    logic [1:0]  bpGrant [8];

    initial begin
        rst = 1'b1;
        req_valid = 2'b00;
        req_x1_0 = 32'd0; req_x2_0 = 32'd0; req_x1_1 = 32'd0; req_x2_1 = 32'd0;
        rsp_ready = 2'b00;

        zA = '{32'h00000000, 32'h80000000, 32'h00800000};
        zB = '{32'h3F800000, 32'h3F800000, 32'h00800000};
        zY = '{32'h00000000, 32'h80000000, 32'h00000000};
        bA = '{32'h40000000, 32'h3FC00000, 32'hBF800000, 32'h3F800000};
        bB = '{32'h40400000, 32'h3FC00000, 32'h40000000, 32'h3F800000};
        bY = '{32'h40C00000, 32'h40100000, 32'hC0000000, 32'h3F800000};
        bpGrant = '{2'b01, 2'b10, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b10};

        // Pin the reference multiplier itself.
        checkOutput("ref_2x3", refMul(32'h40000000, 32'h40400000), 32'h40C00000);
        checkOutput("ref_1p5sq", refMul(32'h3FC00000, 32'h3FC00000), 32'h40100000);
        checkOutput("ref_neg0", refMul(32'h80000000, 32'h3F800000), 32'h80000000);

        // Reset: no grant while rst is high, everything cleared after.
        repeat (2) @(posedge clk);
        applyStimulus(2'b11, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 2'b00, 1'b1);
        @(negedge clk);
        checkOutput("ready_in_reset", {30'd0, req_ready}, 32'd0);
        applyStimulus(2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 1'b0);
        @(negedge clk);
        checkOutput("reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        checkOutput("reset_rsp_y_0", rsp_y_0, 32'd0);
        checkOutput("reset_rsp_y_1", rsp_y_1, 32'd0);

        // Single op, 2.0 * 3.0 on requester 0.
        applyStimulus(2'b01, 32'h40000000, 32'h40400000, 32'd0, 32'd0, 2'b11, 1'b0);
        @(negedge clk);
        checkOutput("single_ready", {30'd0, req_ready}, 32'd1);
        applyStimulus(2'b00, 32'h40000000, 32'h40400000, 32'd0, 32'd0, 2'b11, 1'b0);
        @(negedge clk);
        checkOutput("single_not_yet", {30'd0, rsp_valid}, 32'd0);
        applyStimulus(2'b00, 32'h40000000, 32'h40400000, 32'd0, 32'd0, 2'b11, 1'b0);
        @(negedge clk);
        checkOutput("single_valid", {30'd0, rsp_valid}, 32'd1);
        checkOutput("single_y", rsp_y_0, 32'h40C00000);
        applyStimulus(2'b00, 32'h40000000, 32'h40400000, 32'd0, 32'd0, 2'b11, 1'b0);
        @(negedge clk);
        checkOutput("single_consumed", {30'd0, rsp_valid}, 32'd0);

        // Tie and fairness: grants alternate starting with requester 0.
        doReset();
        for (int j = 0; j < 8; j++) begin
            applyStimulus(2'b11, 32'h3FC00000, 32'h3FC00000, 32'hBF800000, 32'h40000000, 2'b11, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("tie_grant_%0d", j), {30'd0, req_ready}, (j % 2 == 0) ? 32'd1 : 32'd2);
            if (j >= 2) begin
                checkOutput($sformatf("tie_valid_%0d", j), {30'd0, rsp_valid}, (j % 2 == 0) ? 32'd1 : 32'd2);
                if (j % 2 == 0) checkOutput($sformatf("tie_y0_%0d", j), rsp_y_0, 32'h40100000);
                else            checkOutput($sformatf("tie_y1_%0d", j), rsp_y_1, 32'hC0000000);
            end
        end

        // Backpressure on requester 1; releasing it re-enables the grant at once.
        doReset();
        for (int j = 0; j < 8; j++) begin
            applyStimulus(2'b11, 32'h3FC00000, 32'h3FC00000, 32'hBF800000, 32'h40000000,
                          (j == 7) ? 2'b11 : 2'b01, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("bp_grant_%0d", j), {30'd0, req_ready}, {30'd0, bpGrant[j]});
        end

        // Zero and underflow flush.
        doReset();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(2'b01, zA[k], zB[k], 32'd0, 32'd0, 2'b11, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("zero_ready_%0d", k), {30'd0, req_ready}, 32'd1);
            applyStimulus(2'b00, zA[k], zB[k], 32'd0, 32'd0, 2'b11, 1'b0);
            applyStimulus(2'b00, zA[k], zB[k], 32'd0, 32'd0, 2'b11, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("zero_valid_%0d", k), {30'd0, rsp_valid}, 32'd1);
            checkOutput($sformatf("zero_y_%0d", k), rsp_y_0, zY[k]);
        end

        // Reset mid-flight: the last winner before reset is requester 0.
        doReset();
        applyStimulus(2'b10, 32'h3F800000, 32'h40400000, 32'h40000000, 32'h40000000, 2'b00, 1'b0);
        @(negedge clk);
        checkOutput("mid_grant1", {30'd0, req_ready}, 32'd2);
        applyStimulus(2'b01, 32'h3F800000, 32'h40400000, 32'h40000000, 32'h40000000, 2'b00, 1'b0);
        @(negedge clk);
        checkOutput("mid_grant0", {30'd0, req_ready}, 32'd1);
        applyStimulus(2'b00, 32'h3F800000, 32'h40400000, 32'h40000000, 32'h40000000, 2'b00, 1'b1);
        @(negedge clk);
        checkOutput("mid_pre_valid", {30'd0, rsp_valid}, 32'd2);
        applyStimulus(2'b11, 32'h3F800000, 32'h40400000, 32'h40000000, 32'h40000000, 2'b11, 1'b0);
        @(negedge clk);
        checkOutput("mid_post_valid", {30'd0, rsp_valid}, 32'd0);
        checkOutput("mid_post_y1", rsp_y_1, 32'd0);
        checkOutput("mid_tie_to_0", {30'd0, req_ready}, 32'd1);
        applyStimulus(2'b00, 32'h3F800000, 32'h40400000, 32'h40000000, 32'h40000000, 2'b11, 1'b0);
        @(negedge clk);
        checkOutput("mid_no_stale", {30'd0, rsp_valid}, 32'd0);
        applyStimulus(2'b00, 32'h3F800000, 32'h40400000, 32'h40000000, 32'h40000000, 2'b11, 1'b0);
        @(negedge clk);
        checkOutput("mid_new_valid", {30'd0, rsp_valid}, 32'd1);
        checkOutput("mid_new_y0", rsp_y_0, 32'h40400000);

        // Same-port back-to-back: a transfer every other cycle, results in order.
        doReset();
        for (int j = 0; j < 9; j++) begin
            applyStimulus(2'b01, bA[(j / 2 > 3) ? 3 : j / 2], bB[(j / 2 > 3) ? 3 : j / 2],
                          32'd0, 32'd0, 2'b01, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("b2b_grant_%0d", j), {30'd0, req_ready}, (j % 2 == 0) ? 32'd1 : 32'd0);
            if (j >= 2 && j % 2 == 0) begin
                checkOutput($sformatf("b2b_y_%0d", j), rsp_y_0, bY[j / 2 - 1]);
            end
        end
        applyStimulus(2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 2'b11, 1'b0);
        applyStimulus(2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 2'b11, 1'b0);
        applyStimulus(2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 2'b11, 1'b0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
